vrf_write_ctrl: RTL
===================

VRF_WRITE_CTRL -- requirements
Module: vrf_write_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_WIDTH, default 31, address MSB index; DATA_WIDTH, default 63, data MSB index; FIFO_DEPTH, default 4, address-queue entries.
REQ-002 SHALL use one clock; reset is asynchronous and active-low.
REQ-003 SHALL have port clk  input  1  rising-edge clock.
REQ-004 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-005 SHALL have port agu_valid  input  1  address beat valid.
REQ-006 SHALL have port agu_ready  output  1  address beat accepted.
REQ-007 SHALL have port agu_addr  input  ADDR_WIDTH+1  VRF word address.
REQ-008 SHALL have port agu_ben  input  8  byte enables.
REQ-009 SHALL have port agu_start  input  1  first beat of a vector op.
REQ-010 SHALL have port agu_end  input  1  last beat of a vector op.
REQ-011 SHALL have port data_valid  input  1  result data valid.
REQ-012 SHALL have port data_ready  output  1  result data accepted.
REQ-013 SHALL have port data_in  input  DATA_WIDTH+1  result word.
REQ-014 SHALL have port vrf_we  output  1  VRF write strobe.
REQ-015 SHALL have port vrf_addr  output  ADDR_WIDTH+1  write address.
REQ-016 SHALL have port vrf_wdata  output  DATA_WIDTH+1  write data.
REQ-017 SHALL have port vrf_ben  output  8  write byte enables.
REQ-018 SHALL have port busy  output  1  op in progress.
REQ-019 SHALL have port done  output  1  one-cycle op-complete pulse.
REQ-020 SHALL have port wr_count  output  16  beats joined in current/last op.
REQ-021 SHALL have port proto_err  output  1  sticky protocol error.

Function
REQ-022 SHALL queue {addr, ben, start, end} in a FIFO_DEPTH FIFO; a push occurs when agu_valid and agu_ready are both high.
REQ-023 SHALL drive agu_ready = not full, from registered occupancy; there SHALL be no push when full, even when a pop occurs in the same cycle.
REQ-024 SHALL drive data_ready = FIFO not empty, with no bypass; a beat pushed in cycle N is joinable in N+1 at the earliest.
REQ-025 SHALL perform a join when data_valid and data_ready are both high; a join SHALL pop the head in the same cycle.
REQ-026 SHALL, in the cycle after a join, register vrf_addr/vrf_ben/vrf_wdata from the head and data_in, and drive vrf_we = (head ben != 0).
REQ-027 SHALL, when a beat has ben = 0, consume data, count the beat, and keep vrf_we low.
REQ-028 SHALL hold vrf_we at 0 in any cycle not following a join; vrf_addr/vrf_ben/vrf_wdata hold their last values.
REQ-029 SHALL support simultaneous push and pop with occupancy unchanged, and wrap read/write pointers modulo FIFO_DEPTH.
REQ-030 SHALL implement states IDLE, ACTIVE and DONE.
REQ-031 IDLE->ACTIVE SHALL occur on a push with agu_start; that push SHALL clear wr_count to 0.
REQ-032 ACTIVE->DONE SHALL occur on a join whose head has end = 1.
REQ-033 DONE->IDLE SHALL occur after one cycle, or DONE->ACTIVE if a start push occurs in that cycle.
REQ-034 done SHALL be 1 only in DONE, coincident with the vrf_we of the last beat; busy SHALL be 1 only in ACTIVE.
REQ-035 A beat with start = 1 and end = 1 SHALL give IDLE->ACTIVE->DONE with wr_count = 1.
REQ-036 wr_count SHALL increment by 1 per join, saturate at 16'hFFFF, and hold after done until the next start push.
REQ-037 proto_err SHALL be set on a start push while ACTIVE, or on a push without start while IDLE; the beat SHALL still be queued and state SHALL be unchanged.

Reset
REQ-038 Asserting rst low SHALL immediately empty the FIFO, set state to IDLE and clear proto_err.
REQ-039 Reset SHALL force vrf_we/vrf_addr/vrf_wdata/vrf_ben/busy/done/wr_count/data_ready to 0 and agu_ready to 1.
REQ-040 Reset mid-operation SHALL discard all queued beats, with no vrf_we after release.
REQ-041 The first push SHALL be accepted on the first rising edge after rst returns high.

Verification
REQ-042 Push addr 0x20, ben 0xFF, start=end=1, then data 0x1122334455667788 -> vrf_we one cycle after join, addr 0x20, ben 0xFF; done in that same cycle; wr_count = 1.
REQ-043 Push 5 beats with data_valid low -> agu_ready drops after the 4th push; the 5th is held until the first join; all 5 writes occur in order.
REQ-044 4-beat op, last ben = 0x0F -> 4 writes, last vrf_ben = 0x0F, done with 4th write, busy high from the cycle after the 1st push to the 4th write.
REQ-045 Beat with ben = 0x00 mid-op -> data consumed, no vrf_we that cycle, wr_count still increments.
REQ-046 Start push while ACTIVE -> proto_err = 1 until reset.
REQ-047 Reset low after 2 of 4 beats are queued -> outputs cleared per REQ-039; no vrf_we after release.

Source files
------------

// File: rtl/vrf_write_ctrl.sv
// VRF write controller: queues AGU address beats, joins each with a result word
// and issues registered VRF writes, tracking vector-op progress in a small FSM.
module vrf_write_ctrl #(
  parameter int ADDR_WIDTH = 31,
  parameter int DATA_WIDTH = 63,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  agu_valid,
  output logic                  agu_ready,
  input  logic [ADDR_WIDTH:0]   agu_addr,
  input  logic [7:0]            agu_ben,
  input  logic                  agu_start,
  input  logic                  agu_end,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic [DATA_WIDTH:0]   data_in,
  output logic                  vrf_we,
  output logic [ADDR_WIDTH:0]   vrf_addr,
  output logic [DATA_WIDTH:0]   vrf_wdata,
  output logic [7:0]            vrf_ben,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           wr_count,
  output logic                  proto_err
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef struct packed {
    logic [ADDR_WIDTH:0] addr;
    logic [7:0]          ben;
    logic                start;
    logic                last;
  } beat_t;

  typedef enum logic [1:0] {IDLE, ACTIVE, DONE} state_t;

  beat_t               fifo_q [FIFO_DEPTH];
  beat_t               fifo_d [FIFO_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  state_t              state_q, state_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                proto_err_q, proto_err_d;
  logic                vrf_we_q, vrf_we_d;
  logic [ADDR_WIDTH:0] vrf_addr_q, vrf_addr_d;
  logic [DATA_WIDTH:0] vrf_wdata_q, vrf_wdata_d;
  logic [7:0]          vrf_ben_q, vrf_ben_d;

  logic  full, empty, push, join_go, start_go;
  beat_t head;
  logic  unused_head_start;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(FIFO_DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  // Ready flags come straight from registered occupancy, so a full queue
  // refuses a push even if the head is popped in the same cycle.
  assign full       = (cnt_q == CNT_W'(FIFO_DEPTH));
  assign empty      = (cnt_q == '0);
  assign agu_ready  = ~full;
  assign data_ready = ~empty;
  assign push       = agu_valid & ~full;
  assign join_go    = data_valid & ~empty;
  assign head       = fifo_q[rd_ptr_q];
  assign start_go   = push & agu_start & (state_q != ACTIVE);
  assign unused_head_start = head.start;

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      fifo_d[wr_ptr_q] = '{addr: agu_addr, ben: agu_ben, start: agu_start, last: agu_end};
      wr_ptr_d = ptr_inc(wr_ptr_q);
    end
    if (join_go) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, join_go})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    proto_err_d = proto_err_q;
    wr_count_d  = wr_count_q;
    case (state_q)
      IDLE:    if (push && agu_start) state_d = ACTIVE;
      ACTIVE:  if (join_go && head.last) state_d = DONE;
      DONE:    state_d = (push && agu_start) ? ACTIVE : IDLE;
      default: state_d = IDLE;
    endcase
    // Protocol violations are flagged but the beat is still queued.
    if (push && agu_start && state_q == ACTIVE) proto_err_d = 1'b1;
    if (push && !agu_start && state_q == IDLE)  proto_err_d = 1'b1;
    if (start_go)
      wr_count_d = '0;
    else if (join_go && wr_count_q != 16'hFFFF)
      wr_count_d = wr_count_q + 16'd1;
  end

  always_comb begin
    vrf_we_d    = join_go && (head.ben != 8'h00);
    vrf_addr_d  = vrf_addr_q;
    vrf_wdata_d = vrf_wdata_q;
    vrf_ben_d   = vrf_ben_q;
    if (join_go) begin
      vrf_addr_d  = head.addr;
      vrf_wdata_d = data_in;
      vrf_ben_d   = head.ben;
    end
  end

  always_ff @(posedge clk) begin
    fifo_q <= fifo_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      state_q     <= IDLE;
      wr_count_q  <= '0;
      proto_err_q <= 1'b0;
      vrf_we_q    <= 1'b0;
      vrf_addr_q  <= '0;
      vrf_wdata_q <= '0;
      vrf_ben_q   <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      state_q     <= state_d;
      wr_count_q  <= wr_count_d;
      proto_err_q <= proto_err_d;
      vrf_we_q    <= vrf_we_d;
      vrf_addr_q  <= vrf_addr_d;
      vrf_wdata_q <= vrf_wdata_d;
      vrf_ben_q   <= vrf_ben_d;
    end
  end

  assign vrf_we    = vrf_we_q;
  assign vrf_addr  = vrf_addr_q;
  assign vrf_wdata = vrf_wdata_q;
  assign vrf_ben   = vrf_ben_q;
  assign busy      = (state_q == ACTIVE);
  assign done      = (state_q == DONE);
  assign wr_count  = wr_count_q;
  assign proto_err = proto_err_q;

endmodule
